trig_phase_sequencer: RTL and testbench

//  Per-octave, per-bin phase-counter bank that drives the sin/cos table address stream.

---
 rtl/trig_phase_sequencer.sv | 132 +++++++++++++
 tb/tb_trig_phase_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/trig_phase_sequencer.sv
// Per-octave, per-bin phase-counter bank feeding the sin/cos table address stream.
// Each accepted sample sweeps every bin of one octave and then advances that bin's phase.
module trig_phase_sequencer #(
   parameter int NS      = 6,
   parameter int BINS    = 24,
   parameter int OCTAVES = 5,
   parameter logic [BINS*NS-1:0] BIN_LEN = {
      6'd29, 6'd29, 6'd30, 6'd31, 6'd32, 6'd33, 6'd34, 6'd35,
      6'd36, 6'd37, 6'd38, 6'd39, 6'd40, 6'd41, 6'd43, 6'd44,
      6'd45, 6'd46, 6'd48, 6'd49, 6'd51, 6'd52, 6'd53, 6'd55},
   localparam int BW = (BINS > 1) ? $clog2(BINS) : 1,
   localparam int OW = (OCTAVES > 1) ? $clog2(OCTAVES) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          phase_clr,
   input  logic          sample_valid,
   input  logic [OW-1:0] sample_octave,
   output logic          sample_ready,
   output logic          addr_valid,
   input  logic          addr_ready,
   output logic [OW-1:0] addr_octave,
   output logic [BW-1:0] addr_bin,
   output logic [NS-1:0] addr_pos,
   output logic          addr_last,
   output logic          err_octave
);

   localparam int NCNT = OCTAVES * BINS;
   localparam int CW   = (NCNT > 1) ? $clog2(NCNT) : 1;

   // Handshakes: a transfer happens on a rising clk edge where valid && ready are both
   // high; the addr_* beat is held unchanged while addr_valid && !addr_ready.
   typedef enum logic {IDLE, SWEEP} state_t;

   state_t state, state_n;

   logic [NS-1:0] cnt [NCNT];

   logic          beat;
   logic          start;
   logic          clr_all;
   logic          err_set;
   logic          oct_ok;
   logic [CW-1:0] start_idx;
   logic [CW-1:0] wr_idx;
   logic [NS-1:0] cur_len;
   logic [NS:0]   pos_inc;
   logic [NS-1:0] wr_val;
   logic [BW-1:0] bin_nx;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n      = state;
      sample_ready = 1'b0;
      start        = 1'b0;
      clr_all      = 1'b0;
      err_set      = 1'b0;
      beat         = addr_valid && addr_ready;
      oct_ok       = ({1'b0, sample_octave} < (OW+1)'(OCTAVES));
      case (state)
         IDLE: begin
            sample_ready = !phase_clr;
            if (phase_clr) begin
               clr_all = 1'b1;
            end else if (sample_valid) begin
               if (oct_ok) begin
                  start   = 1'b1;
                  state_n = SWEEP;
               end else begin
                  err_set = 1'b1;
               end
            end
         end
         SWEEP: begin
            if (beat && addr_last) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Counter index arithmetic; the next bin of the same octave is always wr_idx + 1.
   always_comb begin
      start_idx = CW'(sample_octave) * CW'(BINS);
      wr_idx    = CW'(addr_octave) * CW'(BINS) + CW'(addr_bin);
      cur_len   = BIN_LEN[addr_bin*NS +: NS];
      pos_inc   = {1'b0, addr_pos} + (NS+1)'(1);
      wr_val    = (pos_inc >= {1'b0, cur_len}) ? '0 : pos_inc[NS-1:0];
      bin_nx    = addr_bin + BW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
         addr_valid  <= 1'b0;
         addr_octave <= '0;
         addr_bin    <= '0;
         addr_pos    <= '0;
         addr_last   <= 1'b0;
         err_octave  <= 1'b0;
      end else begin
         err_octave <= err_set;
         if (clr_all) begin
            for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
         end
         if (start) begin
            addr_valid  <= 1'b1;
            addr_octave <= sample_octave;
            addr_bin    <= '0;
            addr_pos    <= cnt[start_idx];
            addr_last   <= (BINS == 1);
         end
         if (beat) begin
            cnt[wr_idx] <= wr_val;
            if (addr_last) begin
               addr_valid <= 1'b0;
               addr_last  <= 1'b0;
               addr_bin   <= '0;
            end else begin
               addr_bin  <= bin_nx;
               addr_pos  <= cnt[wr_idx + CW'(1)];
               addr_last <= (bin_nx == BW'(BINS-1));
            end
         end
      end
   end

endmodule

// File: tb/tb_trig_phase_sequencer.sv
// Directed bench for trig_phase_sequencer: a request table driven against a per-bin
// phase model, plus hand sequences for the wrap boundary and mid-sweep reset.
module tb_trig_phase_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       phase_clr;
   logic       sample_valid;
   logic [2:0] sample_octave;
   logic       sample_ready;
   logic       addr_valid;
   logic       addr_ready;
   logic [2:0] addr_octave;
   logic [4:0] addr_bin;
   logic [5:0] addr_pos;
   logic       addr_last;
   logic       err_octave;

   always #5 clk = ~clk;

   trig_phase_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .phase_clr    (phase_clr),
      .sample_valid (sample_valid),
      .sample_octave(sample_octave),
      .sample_ready (sample_ready),
      .addr_valid   (addr_valid),
      .addr_ready   (addr_ready),
      .addr_octave  (addr_octave),
      .addr_bin     (addr_bin),
      .addr_pos     (addr_pos),
      .addr_last    (addr_last),
      .err_octave   (err_octave)
   );

   typedef struct {
      logic clr;
      logic valid;
      int   oct;
      int   mode;       // 0 ready always, 1 ready toggles + input noise, 2 random ready
      logic exp_ready;
      logic exp_err;
      int   exp_beats;
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [14:0] exp_q[$];
   int          mcnt [5][24];
   int          lens [24] = '{55, 53, 52, 51, 49, 48, 46, 45, 44, 43, 41, 40,
                              39, 38, 37, 36, 35, 34, 33, 32, 31, 30, 29, 29};
   vec_t        vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [14:0] mk(input int o, input int b, input int p, input logic l);
      return {3'(o), 5'(b), 6'(p), l};
   endfunction

   task automatic model_clear();
      for (int o = 0; o < 5; o++)
         for (int b = 0; b < 24; b++) mcnt[o][b] = 0;
   endtask

   task automatic model_accept(input int oct);
      for (int b = 0; b < 24; b++) begin
         exp_q.push_back(mk(oct, b, mcnt[oct][b], b == 23));
         mcnt[oct][b] = (mcnt[oct][b] + 1 >= lens[b]) ? 0 : mcnt[oct][b] + 1;
      end
   endtask

   task automatic run_row(input vec_t v, output int p0, output int p23);
      int          cyc;
      int          got;
      logic        stall;
      logic        rdy;
      logic [14:0] act;
      logic [14:0] held;
      logic [14:0] e;
      p0    = -1;
      p23   = -1;
      stall = 1'b0;
      held  = '0;
      @(negedge clk);
      phase_clr     = v.clr;
      sample_valid  = v.valid;
      sample_octave = 3'(v.oct);
      #1;
      chk("sample_ready_req", sample_ready, v.exp_ready);
      if (v.clr) model_clear();
      else if (v.valid && v.oct < 5) model_accept(v.oct);
      @(negedge clk);
      phase_clr    = 1'b0;
      sample_valid = 1'b0;
      chk("err_octave", err_octave, v.exp_err);
      cyc = 0;
      got = 0;
      while (got < v.exp_beats && cyc < 400) begin
         chk("sample_ready_busy", sample_ready, 1'b0);
         chk("addr_valid_busy", addr_valid, 1'b1);
         case (v.mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 2 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         addr_ready = rdy;
         if (v.mode == 1) begin
            phase_clr     = 1'b1;
            sample_valid  = 1'b1;
            sample_octave = 3'($urandom_range(0, 4));
         end
         act = {addr_octave, addr_bin, addr_pos, addr_last};
         if (stall) chk("hold", act, held);
         stall = 1'b0;
         if (addr_valid && rdy && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("beat", act, e);
            if (addr_bin == 5'd0)  p0  = int'(addr_pos);
            if (addr_bin == 5'd23) p23 = int'(addr_pos);
            got++;
         end else if (addr_valid) begin
            stall = 1'b1;
            held  = act;
         end
         @(negedge clk);
         cyc++;
      end
      phase_clr    = 1'b0;
      sample_valid = 1'b0;
      addr_ready   = 1'b0;
      chk("beat_count", got, v.exp_beats);
      if (v.mode == 0 && v.exp_beats > 0) chk("throughput", cyc, v.exp_beats);
      #1;
      chk("addr_valid_end", addr_valid, 1'b0);
      chk("sample_ready_end", sample_ready, 1'b1);
      if (v.exp_err) begin
         @(negedge clk);
         chk("err_pulse_width", err_octave, 1'b0);
      end
   endtask

   initial begin
      int   p0;
      int   p23;
      int   cyc;
      vec_t s;

      rst           = 1'b1;
      phase_clr     = 1'b0;
      sample_valid  = 1'b0;
      sample_octave = 3'd0;
      addr_ready    = 1'b0;
      model_clear();

      vecs[0]  = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 24};
      vecs[1]  = '{1'b0, 1'b1, 0, 1, 1'b1, 1'b0, 24};
      vecs[2]  = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b0, 24};
      vecs[3]  = '{1'b0, 1'b1, 3, 2, 1'b1, 1'b0, 24};
      vecs[4]  = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b0, 24};
      vecs[5]  = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 24};
      vecs[6]  = '{1'b0, 1'b1, 2, 0, 1'b1, 1'b0, 24};
      vecs[7]  = '{1'b1, 1'b1, 2, 0, 1'b0, 1'b0, 0};
      vecs[8]  = '{1'b0, 1'b1, 7, 0, 1'b1, 1'b1, 0};
      vecs[9]  = '{1'b0, 1'b1, 5, 0, 1'b1, 1'b1, 0};
      vecs[10] = '{1'b0, 1'b1, 4, 0, 1'b1, 1'b0, 24};
      vecs[11] = '{1'b0, 1'b1, 1, 1, 1'b1, 1'b0, 24};

      // Clock/reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_addr_valid", addr_valid, 1'b0);
      chk("rst_addr_octave", addr_octave, 3'd0);
      chk("rst_addr_bin", addr_bin, 5'd0);
      chk("rst_addr_pos", addr_pos, 6'd0);
      chk("rst_addr_last", addr_last, 1'b0);
      chk("rst_err_octave", err_octave, 1'b0);
      chk("rst_sample_ready", sample_ready, 1'b1);

      for (int i = 0; i < 12; i++) run_row(vecs[i], p0, p23);

      // Fresh oct0 (cleared above): bin0 wraps after 54, bin23 after 28.
      s = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 24};
      for (int k = 0; k < 56; k++) begin
         run_row(s, p0, p23);
         chk("bin0_pos", p0, k % 55);
         chk("bin23_pos", p23, k % 29);
      end

      // Reset in the middle of a sweep, at the bin 10 beat.
      @(negedge clk);
      sample_valid  = 1'b1;
      sample_octave = 3'd2;
      @(negedge clk);
      sample_valid = 1'b0;
      addr_ready   = 1'b1;
      cyc = 0;
      while (!(addr_valid && addr_bin == 5'd10) && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("reach_bin10", addr_bin, 5'd10);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_addr_valid", addr_valid, 1'b0);
      chk("midrst_addr_bin", addr_bin, 5'd0);
      chk("midrst_addr_pos", addr_pos, 6'd0);
      rst        = 1'b0;
      addr_ready = 1'b0;
      model_clear();
      exp_q.delete();
      s = '{1'b0, 1'b1, 2, 0, 1'b1, 1'b0, 24};
      run_row(s, p0, p23);
      chk("post_rst_oct2_bin0", p0, 0);
      s = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 24};
      run_row(s, p0, p23);
      chk("post_rst_oct0_bin0", p0, 0);
      chk("post_rst_oct0_bin23", p23, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
